router_input_fifo: RTL and testbench

Per-input-port flit buffer that sits directly upstream of the LBDR route-computation stage in each router.
- Stores incoming flits.
- Presents the head flit's type, destination address and payload with first-word-fall-through timing.
- Drives the empty flag that LBDR uses.
- Returns one credit upstream for every flit dequeued, so the link uses credit-based flow control and never overflows.

---
 rtl/router_input_fifo_pkg.sv | 21 ++
 rtl/router_input_fifo_ptr_ctrl.sv | 80 ++++++++
 rtl/router_input_fifo.sv | 68 ++++++
 tb/tb_router_input_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/router_input_fifo_pkg.sv
// Shared definitions for the router input FIFO.
// Holds the flit field layout (type / destination / payload), the
// flit type codes, and the default buffer depth. Nothing in here is
// stateful; every rtl/ file imports it with router_input_fifo_pkg::*.
package router_input_fifo_pkg;

    localparam int FLIT_W         = 32;
    localparam int AXIS_W         = 2;   // width of the destination field
    localparam int FLIT_TYPE_MSB  = 31;
    localparam int FLIT_TYPE_LSB  = 29;
    localparam int DST_MSB        = 28;
    localparam int DST_LSB        = 27;
    localparam int FIFO_DEPTH     = 4;

    typedef enum logic [2:0] {
        FLIT_HEADER = 3'b001,
        FLIT_BODY   = 3'b010,
        FLIT_TAIL   = 3'b100
    } flit_type_e;

endpackage

// File: rtl/router_input_fifo_ptr_ctrl.sv
// Pointer / occupancy control for the router input FIFO.
// Owns the write and read pointers, the occupancy count, the full/empty
// decode, the sticky overflow flag and the registered credit pulse.
// Ports:
//   clk, rst           clock, async active-high reset
//   i_valid_in         upstream flit present
//   i_read_en          downstream consumes head flit
//   o_do_wr            write accepted this cycle (storage write enable)
//   o_wr_ptr/o_rd_ptr  circular buffer pointers
//   o_empty/o_full     decoded from registered count
//   o_credit_out       one pulse per dequeued flit, one cycle after the read
//   o_overflow         sticky: write attempted while full with no read
module fifo_ptr_ctrl
    import router_input_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid_in,
    input  logic             i_read_en,
    output logic             o_do_wr,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_credit_out,
    output logic             o_overflow
);

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_credit;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_DEPTH);
    assign w_do_rd = i_read_en & ~w_empty;
    // A read frees a slot in the same cycle, so a full buffer may still
    // accept a write when it is also being read.
    assign w_do_wr = i_valid_in & (~w_full | w_do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_credit <= w_do_rd;
            if (i_valid_in & w_full & ~w_do_rd) r_overflow <= 1'b1;
        end
    end

    assign o_do_wr      = w_do_wr;
    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_credit_out = r_credit;
    assign o_overflow   = r_overflow;

endmodule

// File: rtl/router_input_fifo.sv
// Per-input-port flit buffer feeding the LBDR route-computation stage.
// First-word-fall-through: the head flit is driven combinationally from
// storage, a flit written at edge N is visible right after edge N.
// Ports:
//   clk, rst     clock, async active-high reset
//   valid_in     upstream flit present on flit_in
//   flit_in      incoming flit
//   read_en      downstream consumes head flit
//   flit_out     head flit (undefined while empty)
//   flit_type    head flit type field
//   dst_addr     head flit destination field
//   empty, full  occupancy flags
//   credit_out   credit-return pulse to upstream
//   overflow     sticky illegal-write flag
module router_input_fifo
    import router_input_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] flit_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic [2:0]            flit_type,
    output logic [AXIS_W-1:0]     dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  credit_out,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic             w_do_wr;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_valid_in   (valid_in),
        .i_read_en    (read_en),
        .o_do_wr      (w_do_wr),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_empty      (empty),
        .o_full       (full),
        .o_credit_out (credit_out),
        .o_overflow   (overflow)
    );

    // Storage needs no reset; the count gates whether contents are valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[w_wr_ptr] <= flit_in;
    end

    assign flit_out  = r_mem[w_rd_ptr];
    assign flit_type = flit_out[FLIT_TYPE_MSB:FLIT_TYPE_LSB];
    assign dst_addr  = flit_out[DST_MSB:DST_LSB];

endmodule

// File: tb/tb_router_input_fifo.sv
module tb_router_input_fifo;
    import router_input_fifo_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] flit_in;
    logic        read_en;
    logic [31:0] flit_out;
    logic [2:0]  flit_type;
    logic [1:0]  dst_addr;
    logic        empty;
    logic        full;
    logic        credit_out;
    logic        overflow;

    int n_vec;
    int n_fail;

    router_input_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .flit_in    (flit_in),
        .read_en    (read_en),
        .flit_out   (flit_out),
        .flit_type  (flit_type),
        .dst_addr   (dst_addr),
        .empty      (empty),
        .full       (full),
        .credit_out (credit_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        r;
        logic [31:0] d;
        logic        e_empty;
        logic        e_full;
        logic        e_cr;
        logic        e_ov;
        logic        chk_flit;
        logic [31:0] e_flit;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample just after the rising edge.
    task automatic step(input logic v, input logic r, input logic [31:0] d);
        @(negedge clk);
        valid_in = v;
        read_en  = r;
        flit_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        read_en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] mk(input flit_type_e t, input logic [1:0] dst, input logic [26:0] p);
        return {t, dst, p};
    endfunction

    logic [31:0] fa, fb, fc, fd, fe, ff, fg, fx, fr, fh;
    logic [31:0] q[$];
    int written, credits, cnt, cyc;
    logic r_rand, v_rand, mdo_rd, prev_rd;

    initial begin
        n_vec = 0;
        n_fail = 0;
        fa = mk(FLIT_HEADER, 2'b01, 27'h00000A1);
        fb = mk(FLIT_BODY,   2'b01, 27'h00000B2);
        fc = mk(FLIT_TAIL,   2'b01, 27'h00000C3);
        fd = mk(FLIT_HEADER, 2'b10, 27'h00000D4);
        fe = mk(FLIT_BODY,   2'b10, 27'h00000E5);
        ff = mk(FLIT_TAIL,   2'b10, 27'h00000F6);
        fg = mk(FLIT_HEADER, 2'b11, 27'h0000017);
        fx = mk(FLIT_BODY,   2'b00, 27'h7BADBAD);
        fr = mk(FLIT_HEADER, 2'b11, 27'h0000123);
        fh = mk(FLIT_TAIL,   2'b00, 27'h0000456);

        //           v     r     d   empty full  cr    ov   chk   flit
        tv[0]  = '{1'b1, 1'b0, fa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fa};
        tv[1]  = '{1'b1, 1'b0, fb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fa};
        tv[2]  = '{1'b1, 1'b0, fc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fa};
        tv[3]  = '{1'b1, 1'b0, fd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, fa};
        tv[4]  = '{1'b1, 1'b1, fe, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, fb};
        tv[5]  = '{1'b1, 1'b1, ff, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, fc};
        tv[6]  = '{1'b1, 1'b1, fg, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, fd};
        tv[7]  = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, fd};
        tv[8]  = '{1'b1, 1'b0, fx, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, fd};
        tv[9]  = '{1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, fe};
        tv[10] = '{1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ff};
        tv[11] = '{1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, fg};
        tv[12] = '{1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tv[13] = '{1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        // Reset held with valid_in asserted: nothing may be written.
        rst = 1'b1;
        valid_in = 1'b1;
        read_en  = 1'b0;
        flit_in  = fx;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty",    32'(empty),      32'd1);
        chk("rst_full",     32'(full),       32'd0);
        chk("rst_credit",   32'(credit_out), 32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);

        // Release with valid_in still high: first write lands after release.
        @(negedge clk);
        flit_in = fr;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_empty", 32'(empty), 32'd0);
        chk("post_rst_flit",  flit_out,   fr);
        step(1'b0, 1'b1, 32'd0);
        chk("post_rst_drain_empty",  32'(empty),      32'd1);
        chk("post_rst_drain_credit", 32'(credit_out), 32'd1);

        // Table: fill, full read+write, hold, overflow, drain, read-while-empty.
        for (int i = 0; i < 14; i++) begin
            step(tv[i].v, tv[i].r, tv[i].d);
            chk($sformatf("v%0d_empty", i),    32'(empty),      32'(tv[i].e_empty));
            chk($sformatf("v%0d_full", i),     32'(full),       32'(tv[i].e_full));
            chk($sformatf("v%0d_credit", i),   32'(credit_out), 32'(tv[i].e_cr));
            chk($sformatf("v%0d_overflow", i), 32'(overflow),   32'(tv[i].e_ov));
            if (tv[i].chk_flit) begin
                chk($sformatf("v%0d_flit", i),  flit_out,          tv[i].e_flit);
                chk($sformatf("v%0d_type", i),  32'(flit_type),    32'(tv[i].e_flit[31:29]));
                chk($sformatf("v%0d_dst", i),   32'(dst_addr),     32'(tv[i].e_flit[28:27]));
            end
        end

        // Overflow is sticky until reset.
        step(1'b0, 1'b0, 32'd0);
        chk("ov_sticky", 32'(overflow), 32'd1);
        do_reset();
        #1;
        chk("ov_cleared", 32'(overflow), 32'd0);

        // Empty buffer, read and write together: write only, no credit.
        step(1'b1, 1'b1, fh);
        chk("er_empty",  32'(empty),      32'd0);
        chk("er_flit",   flit_out,        fh);
        chk("er_credit", 32'(credit_out), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("er_credit2", 32'(credit_out), 32'd0);
        chk("er_flit2",   flit_out,        fh);

        // Reset mid-operation discards contents with no credits.
        step(1'b1, 1'b0, fa);
        do_reset();
        #1;
        chk("midrst_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 32'd0);
        chk("midrst_credit", 32'(credit_out), 32'd0);
        chk("midrst_empty2", 32'(empty),      32'd1);

        // Ten flits with random read gaps, checked against a queue model.
        q.delete();
        written = 0;
        credits = 0;
        prev_rd = 1'b0;
        cyc = 0;
        while ((written < 10 || q.size() > 0) && cyc < 200) begin
            cnt    = q.size();
            r_rand = 1'($urandom_range(0, 1));
            if (written >= 10) r_rand = 1'b1;
            mdo_rd = r_rand && (cnt > 0);
            v_rand = (written < 10) && ((cnt < 4) || mdo_rd);
            step(v_rand, r_rand, 32'h5000_0000 + 32'(written));
            if (mdo_rd) void'(q.pop_front());
            if (v_rand) begin
                q.push_back(32'h5000_0000 + 32'(written));
                written++;
            end
            chk("wrap_credit", 32'(credit_out), 32'(mdo_rd));
            chk("wrap_empty",  32'(empty),      32'(q.size() == 0));
            if (q.size() > 0) chk("wrap_flit", flit_out, q[0]);
            if (credit_out) credits++;
            cyc++;
        end
        step(1'b0, 1'b0, 32'd0);
        chk("wrap_last_credit", 32'(credit_out), 32'd0);
        chk("wrap_credits",  32'(credits),  32'd10);
        chk("wrap_overflow", 32'(overflow), 32'd0);
        chk("wrap_done",     32'(cyc < 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
